// File: rtl/rv32i_types.sv
// Shared RV32 decode types: M-extension funct3 encodings and the funct7 that selects them.
package rv32i_types;

    typedef enum logic [2:0] {
        mul    = 3'b000,
        mulh   = 3'b001,
        mulhsu = 3'b010,
        mulhu  = 3'b011,
        div    = 3'b100,
        divu   = 3'b101,
        rem    = 3'b110,
        remu   = 3'b111
    } muldiv_funct3_t;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiplier and restoring divider sharing
// one hi/lo register pair, one result bit per cycle, start/done handshake with kill.
module muldiv_unit
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  muldiv_funct3_t   funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [WIDTH-1:0]   result_nxt;
    muldiv_funct3_t     op, op_nxt;
    logic               neg, neg_nxt;
    logic [WIDTH-1:0]   opnd, opnd_nxt;
    logic [WIDTH-1:0]   hi, hi_nxt;
    logic [WIDTH-1:0]   lo, lo_nxt;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic               a_signed, b_signed, a_neg, b_neg, neg_start;
    logic               div_zero, div_ovf;
    logic [WIDTH-1:0]   mag_a, mag_b;

    assign a_s       = a;
    assign b_s       = b;
    assign a_signed  = funct3 inside {mulh, mulhsu, div, rem};
    assign b_signed  = funct3 inside {mulh, div, rem};
    assign a_neg     = a_signed && (a_s < 0);
    assign b_neg     = b_signed && (b_s < 0);
    assign mag_a     = a_neg ? -a : a;
    assign mag_b     = b_neg ? -b : b;
    // Remainder takes the dividend's sign; everything else the XOR of both signs.
    assign neg_start = (funct3 inside {rem, remu}) ? a_neg : (a_neg ^ b_neg);
    assign div_zero  = funct3[2] && (b == '0);
    assign div_ovf   = (funct3 inside {div, rem}) && (a == MOST_NEG) && (b == '1);

    // Multiply: hi:lo holds product with the multiplier shifting out of lo.
    // Divide: lo holds dividend shifting out and quotient shifting in; hi is the remainder.
    logic [WIDTH:0]     mul_sum, div_rs, div_diff;
    logic [WIDTH-1:0]   hi_it, lo_it;
    logic [2*WIDTH-1:0] prod, prod_f;
    logic [WIDTH-1:0]   quo_f, rem_f, fin;

    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign div_rs   = {hi, lo[WIDTH-1]};
    assign div_diff = div_rs - {1'b0, opnd};

    always_comb begin
        hi_it = {mul_sum[WIDTH:1]};
        lo_it = {mul_sum[0], lo[WIDTH-1:1]};
        if (op[2]) begin
            if (!div_diff[WIDTH]) begin
                hi_it = div_diff[WIDTH-1:0];
                lo_it = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_it = div_rs[WIDTH-1:0];
                lo_it = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign prod   = {hi_it, lo_it};
    assign prod_f = neg ? -prod : prod;
    assign quo_f  = neg ? -lo_it : lo_it;
    assign rem_f  = neg ? -hi_it : hi_it;

    always_comb begin
        fin = prod_f[WIDTH-1:0];
        case (op)
            mulh, mulhsu, mulhu: fin = prod_f[2*WIDTH-1:WIDTH];
            div, divu:           fin = quo_f;
            rem, remu:           fin = rem_f;
            default:             fin = prod_f[WIDTH-1:0];
        endcase
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        result_nxt = result;
        op_nxt     = op;
        neg_nxt    = neg;
        opnd_nxt   = opnd;
        hi_nxt     = hi;
        lo_nxt     = lo;
        case (state)
            IDLE: begin
                if (start && !kill) begin
                    op_nxt   = funct3;
                    neg_nxt  = neg_start;
                    cnt_nxt  = CW'(WIDTH);
                    hi_nxt   = '0;
                    opnd_nxt = funct3[2] ? mag_b : mag_a;
                    lo_nxt   = funct3[2] ? mag_a : mag_b;
                    if (div_zero) begin
                        result_nxt = funct3[1] ? a : '1;
                        state_nxt  = DONE;
                    end else if (div_ovf) begin
                        result_nxt = funct3[1] ? '0 : a;
                        state_nxt  = DONE;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (kill) begin
                    state_nxt = IDLE;
                end else begin
                    hi_nxt  = hi_it;
                    lo_nxt  = lo_it;
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result_nxt = fin;
                        state_nxt  = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            result <= result_nxt;
        end
    end

    always_ff @(posedge clk) begin
        op   <= op_nxt;
        neg  <= neg_nxt;
        opnd <= opnd_nxt;
        hi   <= hi_nxt;
        lo   <= lo_nxt;
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table on 32-bit and 8-bit instances plus
// hand-written kill, start-while-busy and reset sequences.
module tb_muldiv_unit;
    import rv32i_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           kill = 1'b0;
    muldiv_funct3_t funct3 = mul;
    logic [31:0]    a = '0, b = '0;
    logic           start32 = 1'b0, start8 = 1'b0;
    logic           busy32, done32, busy8, done8;
    logic [31:0]    result32;
    logic [7:0]     result8;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .kill(kill), .funct3(funct3),
        .a(a), .b(b), .busy(busy32), .done(done32), .result(result32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .kill(kill), .funct3(funct3),
        .a(a[7:0]), .b(b[7:0]), .busy(busy8), .done(done8), .result(result8)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit             w8;
        muldiv_funct3_t f;
        logic [31:0]    av;
        logic [31:0]    bv;
        logic [31:0]    exp;
        int             lat;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic cur_done(input bit w8);
        return w8 ? done8 : done32;
    endfunction

    function automatic logic cur_busy(input bit w8);
        return w8 ? busy8 : busy32;
    endfunction

    function automatic logic [31:0] cur_res(input bit w8);
        return w8 ? {24'h0, result8} : result32;
    endfunction

    // Latency counts edges from the accepting edge up to the edge that raises done.
    task automatic run_op(input string nm, input vec_t v);
        int n;
        @(negedge clk);
        funct3 = v.f; a = v.av; b = v.bv;
        if (v.w8) start8 = 1'b1; else start32 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start32 = 1'b0;
        n = 1;
        while (!cur_done(v.w8) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_lat"}, 64'(n), 64'(v.lat));
        check({nm, "_res"}, 64'(cur_res(v.w8)), 64'(v.exp));
        @(posedge clk); #1;
        check({nm, "_idle"}, {62'h0, cur_busy(v.w8), cur_done(v.w8)}, 64'h0);
    endtask

    initial begin
        int ndone;
        logic [31:0] seen;

        vecs[0]  = '{1'b0, mul,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{1'b0, mulh,   32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
        vecs[2]  = '{1'b0, mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{1'b0, mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{1'b0, div,    32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFA, 33};
        vecs[5]  = '{1'b0, rem,    32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE, 33};
        vecs[6]  = '{1'b0, divu,   32'd20,       32'd3,        32'd6,        33};
        vecs[7]  = '{1'b0, remu,   32'd20,       32'd3,        32'd2,        33};
        vecs[8]  = '{1'b0, div,    32'd5,        32'd0,        32'hFFFF_FFFF, 1};
        vecs[9]  = '{1'b0, rem,    32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{1'b0, div,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{1'b0, rem,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1};
        vecs[12] = '{1'b0, mul,    32'h0001_0000, 32'h0001_0000, 32'd0,        33};
        vecs[13] = '{1'b0, mulhu,  32'h0001_0000, 32'h0001_0000, 32'd1,        33};
        vecs[14] = '{1'b0, div,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33};
        vecs[15] = '{1'b0, rem,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33};
        vecs[16] = '{1'b0, divu,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        33};
        vecs[17] = '{1'b0, remu,   32'd9,        32'd0,        32'd9,        1};
        vecs[18] = '{1'b0, div,    32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 33};
        vecs[19] = '{1'b1, mulhu,  32'hFF,       32'hFF,       32'hFE,       9};
        vecs[20] = '{1'b1, mul,    32'hFF,       32'hFF,       32'h01,       9};
        vecs[21] = '{1'b1, div,    32'h80,       32'hFF,       32'h80,       1};

        repeat (2) @(posedge clk);
        #1;
        check("reset32", {busy32, done32, result32}, 64'h0);
        check("reset8", {busy8, done8, result8}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_op($sformatf("vec%0d", i), vecs[i]);

        // Known prior result before the kill sequence.
        run_op("prekill", '{1'b0, divu, 32'd20, 32'd3, 32'd6, 33});

        @(negedge clk);
        funct3 = mul; a = 32'd7; b = 32'hFFFF_FFFD; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        check("kill_busy_before", 64'(busy32), 64'h1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy_after", 64'(busy32), 64'h0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done32) ndone++;
        end
        check("kill_no_done", 64'(ndone), 64'h0);
        check("kill_result_held", 64'(result32), 64'd6);

        // Second start mid-operation must be dropped.
        @(negedge clk);
        funct3 = divu; a = 32'd100; b = 32'd7; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        funct3 = mul; a = 32'd2; b = 32'd2; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        ndone = 0;
        seen = '0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done32) begin
                ndone++;
                seen = result32;
            end
        end
        check("busy_start_done_count", 64'(ndone), 64'h1);
        check("busy_start_result", 64'(seen), 64'd14);

        // Kill and start together in IDLE: kill wins.
        @(negedge clk);
        funct3 = mul; a = 32'd3; b = 32'd3; start32 = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0; kill = 1'b0;
        check("kill_start_idle", 64'(busy32), 64'h0);

        // Reset mid-divide.
        @(negedge clk);
        funct3 = divu; a = 32'd50; b = 32'd5; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_op", {busy32, done32, result32}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done32) ndone++;
        end
        check("rst_no_done", 64'(ndone), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit implementing the RV32M operations alongside the existing single-cycle ALU in the execute stage. It accepts one operation at a time over a start/done handshake and computes one result bit per cycle with a shift-add multiplier and a restoring divider. Width is generic so the same unit serves RV32 and a future RV64 datapath. A kill input aborts an in-flight operation on pipeline flush.

## Interface
- WIDTH, 32, operand/result width in bits; legal values ≥ 4, even.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- kill  in  1  abort current operation; no done produced.
- funct3  in  3  muldiv_funct3_t operation select, sampled with start.
- a  in  WIDTH  rs1 operand, sampled with start.
- b  in  WIDTH  rs2 operand, sampled with start.
- busy  out  1  high in BUSY and DONE states.
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  WIDTH  last completed result; held until next done.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE & start & !kill: latch funct3, magnitudes of operands per signedness, result sign, iteration counter = WIDTH; go BUSY. Division fast path (see below) goes directly to DONE.
- BUSY: one iteration per cycle, counter decrements; when counter reaches 1 at cycle end, go DONE.
- DONE: done=1, result updated in the same edge that entered DONE; next state IDLE unconditionally.
- kill in IDLE or BUSY: next state IDLE, no done, result unchanged. kill in DONE: done still seen this cycle (already registered).
- start while busy=1: ignored, no queuing.
- Ops: mul = low WIDTH of a*b; mulh signed×signed high; mulhsu signed a × unsigned b high; mulhu unsigned high; div/divu quotient; rem/remu remainder.
- Signed handling: operate on magnitudes, negate 2·WIDTH product if signs differ; quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- Division fast path (no iteration): b==0 → quotient all-ones, remainder = a; signed overflow (a = most-negative, b = −1) → quotient = a, remainder = 0.
- All arithmetic modulo 2^WIDTH; product accumulator 2·WIDTH bits; divider partial remainder WIDTH+1 bits.

## Timing
- Reset: state IDLE, busy=0, done=0, result=0, counter=0.
- Normal latency: start accepted edge t → done high in cycle t+WIDTH+1 (WIDTH BUSY cycles, 1 DONE cycle).
- Fast path: done high in cycle t+1.
- Back-to-back: earliest next start accepted the cycle after done (IDLE); issue interval WIDTH+2.
- busy asserted from the cycle after accepted start through the done cycle.
- rst mid-operation: returns to reset values next edge, overrides kill/start.
- kill and start same cycle in IDLE: kill wins, start dropped.

## Structure
- Add to rv32i_types: enum muldiv_funct3_t {mul=3'b000, mulh=3'b001, mulhsu=3'b010, mulhu=3'b011, div=3'b100, divu=3'b101, rem=3'b110, remu=3'b111}; add constant funct7 value 7'b0000001 for M-extension decode.
- State enum local to module.
- Single module; no sub-module needed. Counter width $clog2(WIDTH)+1.

## Test plan
- mul a=7, b=−3 (0xFFFFFFFD), WIDTH=32 → done at t+33, result 0xFFFFFFEB; mulh same operands → 0xFFFFFFFF.
- mulhu a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE; mulhsu a=−1, b=0xFFFFFFFF → 0xFFFFFFFF.
- div a=−20, b=3 → 0xFFFFFFFA (−6); rem → 0xFFFFFFFE (−2); divu 20/3 → 6, remu → 2.
- div by zero a=5, b=0 → done at t+1, result 0xFFFFFFFF; rem → 5. div 0x80000000 / −1 → 0x80000000 at t+1; rem → 0.
- kill asserted at t+10 of mul → no done, busy=0 from t+11, result retains prior value; start during BUSY ignored (done count stays 1).
- rst at t+5 of divu → all outputs 0 next cycle; WIDTH=8 instance: mulhu 0xFF×0xFF → 0xFE, done at t+9.
